and_gate_response_checker: RTL and testbench

AND_GATE_RESPONSE_CHECKER -- requirements
Module: and_gate_response_checker

---
 rtl/and_gate_response_checker.sv | 128 ++++++++++++
 tb/tb_and_gate_response_checker.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_response_checker.sv
// Session-based checker for a 2-input AND gate. It counts matching and mismatching
// samples, tracks input coverage and reports pass or timeout.
module and_gate_response_checker #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov_mask,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int               TMO_W     = 16;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, next_state;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
  logic [CNT_W-1:0] pass_cnt_next, fail_cnt_next;
  logic [3:0]       cov_next;
  logic [2:0]       err_vec_next;
  logic             err_valid_next;
  logic             timeout_next;
  logic             busy_next, done_next, pass_next;
  logic [1:0]       sample_idx;
  logic             match;

  assign sample_idx = {a, b};
  assign match      = (y == (a & b));

  always_comb begin
    // NOTE: every value written here gets a default first, so no latches are inferred.
    next_state     = state;
    tmo_next       = tmo_cnt;
    pass_cnt_next  = pass_cnt;
    fail_cnt_next  = fail_cnt;
    cov_next       = cov_mask;
    err_vec_next   = first_err_vec;
    err_valid_next = first_err_valid;
    timeout_next   = timeout;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state     = RUN;
          tmo_next       = '0;
          pass_cnt_next  = '0;
          fail_cnt_next  = '0;
          cov_next       = 4'b0000;
          err_vec_next   = 3'b000;
          err_valid_next = 1'b0;
          timeout_next   = 1'b0;
        end
      end
      RUN: begin
        tmo_next = tmo_cnt + 1'b1;
        if (sample_valid) begin
          cov_next = cov_mask | (4'b0001 << sample_idx);
          if (match) begin
            if (pass_cnt != CNT_MAX) pass_cnt_next = pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt_next = fail_cnt + 1'b1;
            if (!first_err_valid) begin
              err_valid_next = 1'b1;
              err_vec_next   = {a, b, y};
            end
          end
        end
        // Completing coverage takes priority over running out of cycles.
        if (cov_next == 4'b1111) begin
          next_state = DONE;
        end else if (tmo_next == TMO_LIMIT) begin
          next_state   = DONE;
          timeout_next = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase

    busy_next = (next_state == RUN);
    done_next = (next_state == DONE);
    pass_next = done_next && (cov_next == 4'b1111) && (fail_cnt_next == '0) && !timeout_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      cov_mask        <= 4'b0000;
      first_err_vec   <= 3'b000;
      first_err_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state           <= next_state;
      tmo_cnt         <= tmo_next;
      busy            <= busy_next;
      done            <= done_next;
      pass            <= pass_next;
      timeout         <= timeout_next;
      pass_cnt        <= pass_cnt_next;
      fail_cnt        <= fail_cnt_next;
      cov_mask        <= cov_next;
      first_err_vec   <= err_vec_next;
      first_err_valid <= err_valid_next;
    end
  end

endmodule

// File: tb/tb_and_gate_response_checker.sv
// Bench for and_gate_response_checker: three instances (default, CNT_W=2, TIMEOUT=8)
// share stimulus and are compared against a session-level reference model.
module tb_and_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, sample_valid, a, b, y;

  logic       busy0, done0, pass0, tmo0, fevv0;
  logic [7:0] pc0, fc0;
  logic [3:0] cov0;
  logic [2:0] fev0;

  logic       busy1, done1, pass1, tmo1, fevv1;
  logic [1:0] pc1, fc1;
  logic [3:0] cov1;
  logic [2:0] fev1;

  logic       busy2, done2, pass2, tmo2, fevv2;
  logic [7:0] pc2, fc2;
  logic [3:0] cov2;
  logic [2:0] fev2;

  and_gate_response_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .y(y), .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
    .pass_cnt(pc0), .fail_cnt(fc0), .cov_mask(cov0), .first_err_vec(fev0),
    .first_err_valid(fevv0));

  and_gate_response_checker #(.CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .y(y), .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
    .pass_cnt(pc1), .fail_cnt(fc1), .cov_mask(cov1), .first_err_vec(fev1),
    .first_err_valid(fevv1));

  and_gate_response_checker #(.TIMEOUT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .a(a), .b(b), .y(y), .busy(busy2), .done(done2), .pass(pass2), .timeout(tmo2),
    .pass_cnt(pc2), .fail_cnt(fc2), .cov_mask(cov2), .first_err_vec(fev2),
    .first_err_valid(fevv2));

  int checks = 0;
  int errors = 0;

  // Reference model: a session is waiting, running or finished.
  localparam int PH_WAIT = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_END  = 2;

  typedef struct {
    int         phase;
    int         cycles;
    int         pc;
    int         fc;
    logic [3:0] cov;
    logic [2:0] fe;
    bit         fe_valid;
    bit         timed_out;
  } model_t;

  model_t m[3];
  int cmax[3] = '{255, 3, 255};
  int tlim[3] = '{64, 64, 8};

  task automatic model_clear(input int k, input int ph);
    m[k].phase     = ph;
    m[k].cycles    = 0;
    m[k].pc        = 0;
    m[k].fc        = 0;
    m[k].cov       = 4'b0000;
    m[k].fe        = 3'b000;
    m[k].fe_valid  = 1'b0;
    m[k].timed_out = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) model_clear(k, PH_WAIT);
  endtask

  task automatic model_step(input bit st, input bit sv, input bit ai, input bit bi, input bit yi);
    for (int k = 0; k < 3; k++) begin
      if (m[k].phase != PH_RUN) begin
        if (st) model_clear(k, PH_RUN);
      end else begin
        m[k].cycles++;
        if (sv) begin
          if (yi == (ai & bi)) begin
            if (m[k].pc < cmax[k]) m[k].pc++;
          end else begin
            if (m[k].fc < cmax[k]) m[k].fc++;
            if (!m[k].fe_valid) begin
              m[k].fe_valid = 1'b1;
              m[k].fe       = {ai, bi, yi};
            end
          end
          m[k].cov[{ai, bi}] = 1'b1;
        end
        if (m[k].cov == 4'hF) begin
          m[k].phase = PH_END;
        end else if (m[k].cycles >= tlim[k]) begin
          m[k].phase     = PH_END;
          m[k].timed_out = 1'b1;
        end
      end
    end
  endtask

  // Packing: {4'b0, busy, done, pass, timeout, pass_cnt[7:0], fail_cnt[7:0], cov, first_err_vec, first_err_valid}
  function automatic logic [31:0] exp_vec(input int k);
    return {4'b0, m[k].phase == PH_RUN, m[k].phase == PH_END,
            (m[k].phase == PH_END) && (m[k].cov == 4'hF) && (m[k].fc == 0) && !m[k].timed_out,
            m[k].timed_out, 8'(m[k].pc), 8'(m[k].fc), m[k].cov, m[k].fe, m[k].fe_valid};
  endfunction

  function automatic logic [31:0] obs_vec(input int k);
    case (k)
      0:       return {4'b0, busy0, done0, pass0, tmo0, pc0, fc0, cov0, fev0, fevv0};
      1:       return {4'b0, busy1, done1, pass1, tmo1, 6'b0, pc1, 6'b0, fc1, cov1, fev1, fevv1};
      default: return {4'b0, busy2, done2, pass2, tmo2, pc2, fc2, cov2, fev2, fevv2};
    endcase
  endfunction

  task automatic tick(input bit st, input bit sv, input bit ai, input bit bi, input bit yi);
    @(negedge clk);
    start = st; sample_valid = sv; a = ai; b = bi; y = yi;
    @(posedge clk);
    model_step(st, sv, ai, bi, yi);
    #1;
  endtask

  task automatic vec(input logic [2:0] v);
    tick(1'b0, 1'b1, v[2], v[1], v[0]);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 1'b0; sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== 32'h0) begin
        errors++; $display("FAIL reset_state dut%0d got %h want %h", k, obs_vec(k), 32'h0);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (busy0 !== 1'b0 || pc0 !== 8'd0 || cov0 !== 4'b0000) begin
      errors++; $display("FAIL idle_sample_ignored busy=%b pc=%0d cov=%b want 0 0 0000", busy0, pc0, cov0);
    end
  endtask

  task automatic test_full_pass();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL start_to_run busy got %b want 1", busy0); end
    vec(3'b000); vec(3'b010); vec(3'b100);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL early_done done/busy got %b/%b want 0/1", done0, busy0);
    end
    vec(3'b111);
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0 || pc0 !== 8'd4 || fc0 !== 8'd0 || cov0 !== 4'hF) begin
      errors++;
      $display("FAIL full_pass done=%b pass=%b busy=%b pc=%0d fc=%0d cov=%b want 1 1 0 4 0 1111",
               done0, pass0, busy0, pc0, fc0, cov0);
    end
    vec(3'b110);
    checks++;
    if (fc0 !== 8'd0 || done0 !== 1'b1 || pass0 !== 1'b1) begin
      errors++; $display("FAIL done_hold fc=%0d done=%b pass=%b want 0 1 1", fc0, done0, pass0);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL full_pass_model dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_mismatch();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b110); vec(3'b110); vec(3'b000); vec(3'b010); vec(3'b100);
    checks++;
    if (fc0 !== 8'd2 || pc0 !== 8'd3 || fev0 !== 3'b110 || fevv0 !== 1'b1 || pass0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_before_cov fc=%0d pc=%0d fev=%b fevv=%b pass=%b done=%b want 2 3 110 1 0 1",
               fc0, pc0, fev0, fevv0, pass0, done0);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b000); vec(3'b010); vec(3'b100); vec(3'b110); vec(3'b110);
    checks++;
    if (fc0 !== 8'd1 || fev0 !== 3'b110 || fevv0 !== 1'b1 || pass0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_after_cov fc=%0d fev=%b fevv=%b pass=%b done=%b want 1 110 1 0 1",
               fc0, fev0, fevv0, pass0, done0);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL mismatch_model dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_saturation();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) vec(3'b000);
    vec(3'b010); vec(3'b100); vec(3'b111);
    checks++;
    if (pc1 !== 2'd3 || fc1 !== 2'd0 || done1 !== 1'b1 || pass1 !== 1'b1 || pc0 !== 8'd9) begin
      errors++;
      $display("FAIL saturation pc1=%0d fc1=%0d done1=%b pass1=%b pc0=%0d want 3 0 1 1 9",
               pc1, fc1, done1, pass1, pc0);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL saturation_model dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) vec((i % 2 == 0) ? 3'b000 : 3'b010);
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++; $display("FAIL timeout_early busy=%b done=%b want 1 0", busy2, done2);
    end
    vec(3'b000);
    checks++;
    if (done2 !== 1'b1 || tmo2 !== 1'b1 || pass2 !== 1'b0 || cov2 !== 4'b0011 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL timeout done=%b tmo=%b pass=%b cov=%b busy=%b want 1 1 0 0011 0",
               done2, tmo2, pass2, cov2, busy2);
    end
    // Coverage completes on the very cycle the budget runs out.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b000); vec(3'b010); vec(3'b100);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b111);
    checks++;
    if (done2 !== 1'b1 || tmo2 !== 1'b0 || pass2 !== 1'b1 || cov2 !== 4'hF) begin
      errors++;
      $display("FAIL cov_beats_timeout done=%b tmo=%b pass=%b cov=%b want 1 0 1 1111", done2, tmo2, pass2, cov2);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL timeout_model dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_restart();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b000); vec(3'b011);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy0 !== 1'b1 || pc0 !== 8'd1 || fc0 !== 8'd1 || cov0 !== 4'b0011 || fevv0 !== 1'b1 || fev0 !== 3'b011) begin
      errors++;
      $display("FAIL start_in_run busy=%b pc=%0d fc=%0d cov=%b fevv=%b fev=%b want 1 1 1 0011 1 011",
               busy0, pc0, fc0, cov0, fevv0, fev0);
    end
    vec(3'b100); vec(3'b111);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || pc0 !== 8'd0 || fc0 !== 8'd0 || cov0 !== 4'b0000 || fevv0 !== 1'b0 || fev0 !== 3'b000) begin
      errors++;
      $display("FAIL start_in_done busy=%b done=%b pc=%0d fc=%0d cov=%b fevv=%b fev=%b want 1 0 0 0 0000 0 000",
               busy0, done0, pc0, fc0, cov0, fevv0, fev0);
    end
    vec(3'b000); vec(3'b010); vec(3'b100); vec(3'b111);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL restart_model dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b000); vec(3'b010);
    async_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== 32'h0) begin
        errors++; $display("FAIL reset_mid_run dut%0d got %h want %h", k, obs_vec(k), 32'h0);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b111);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || pc0 !== 8'd0) begin
      errors++; $display("FAIL wait_after_reset busy=%b done=%b pc=%0d want 0 0 0", busy0, done0, pc0);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3'b000); vec(3'b010); vec(3'b100); vec(3'b111);
    checks++;
    if (pc0 !== 8'd4 || fc0 !== 8'd0 || pass0 !== 1'b1 || done0 !== 1'b1) begin
      errors++; $display("FAIL after_reset_session pc=%0d fc=%0d pass=%b done=%b want 4 0 1 1", pc0, fc0, pass0, done0);
    end
  endtask

  task automatic test_random();
    bit st, sv, ai, bi, yi;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        @(negedge clk) rst_n = 1'b1;
      end
      st = ($urandom_range(0, 15) == 0);
      sv = ($urandom_range(0, 3) != 0);
      ai = 1'($urandom_range(0, 1));
      bi = 1'($urandom_range(0, 1));
      yi = (ai & bi) ^ ($urandom_range(0, 7) == 0);
      tick(st, sv, ai, bi, yi);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL random dut%0d cycle %0d got %h want %h", k, cyc, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_mismatch();
    test_saturation();
    test_timeout();
    test_restart();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
